state_seq_gen: RTL and testbench
================================

Name: state_seq_gen

Overview:
- Parametrised autonomous state-sequence generator: STATE_W-bit state register stepped through a run-time programmable next-state table.
- Output y is a programmable OR-reduction of the state bits.
- Built-in monitor reports the sequence period back to RESET_STATE, self-loop lockups and sequences that never return.
- Serves as the lab-wide replacement for hand-coded small sequential circuits: the same block is reprogrammed instead of rewritten.

Parameters:
- STATE_W, 3: state width in bits; table depth = 2**STATE_W.
- RESET_STATE, 0: state value loaded on reset and used as the period reference point.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance state this cycle.
- tbl_wr_en  input  1  write one next-state table entry.
- tbl_wr_addr  input  STATE_W  entry (current-state value) to write.
- tbl_wr_data  input  STATE_W  next-state value to store.
- mask_wr_en  input  1  load y_mask.
- mask_in  input  STATE_W  new output mask.
- state  output  STATE_W  current state register.
- y  output  1  |(state & y_mask), combinational from registers.
- period_valid  output  1  one-cycle pulse when a period completes.
- period  output  STATE_W+1  last measured period in advances.
- stuck  output  1  sticky self-loop flag.
- no_return  output  1  sticky flag: 2**STATE_W advances without reaching RESET_STATE.
- parity_err  output  1  table parity error (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state=RESET_STATE; y_mask=all ones; table[i]=(i+1) mod 2**STATE_W (binary counter).
  - Internal cnt=0; period=0; period_valid=0; stuck=0; no_return=0; parity_err=0.
  - Reset overrides all other inputs in the same cycle. Reset mid-sequence discards any partial period.
- Advance: en=1 -> state <= table[state] next edge, one cycle latency. en=0 -> state holds and the monitor is idle.
- Table write: tbl_wr_en=1 writes table[tbl_wr_addr] at the edge.
  - Simultaneous en with tbl_wr_addr==state: the advance uses the old entry (read-before-write).
  - Any table write clears stuck and no_return and restarts cnt at 0. period is retained.
- Mask: mask_wr_en loads y_mask; y reflects the new mask the cycle after the write.
- Period monitor, on each advance:
  - next==RESET_STATE: period <= cnt+1, period_valid=1 for one cycle, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - When cnt+1 reaches 2**STATE_W without a return, no_return <= 1 and cnt saturates.
  - Maximum period is 2**STATE_W, which fits in STATE_W+1 bits.
- Stuck: an advance with table[state]==state sets stuck (sticky). If state==RESET_STATE it also pulses period_valid with period=1 on every advance.
- All outputs except y are registered.

Optional Feature:
- Macro: STATE_SEQ_GEN_PARITY_EN.
- Defined:
  - Each table entry stores an even-parity bit computed on write.
  - Each advance checks the parity of the entry read; a mismatch sets parity_err (sticky until reset) and the state still advances.
  - Bench hook: the parity bit is writable for fault injection.
- Undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Package state_seq_gen_pkg:
  - function default_next(i, w), the counter-table init;
  - function period_w(w)=w+1;
  - localparam-style helper for table depth.
- One sub-module, seq_period_mon: cnt, period, period_valid and no_return. Inputs advance, next_is_ref and clear.
- Table, state register, mask and stuck stay in the top.

Test Plan:
- Reset, en=1 for 8 cycles (STATE_W=3) -> state 1,2,...,7,0; period_valid pulses once on the cycle state becomes 0, period=8; stuck=0, no_return=0.
- Write table[2]=2, start from reset, en=1 -> state 1,2,2,2; stuck=1 after the third advance. A following write to table[2]=3 clears stuck.
- Write table[1]=2, table[2]=1, en=1 continuously -> state alternates 2,1,...; no_return=1 after the 8th advance; period stays 0.
- mask_in=3'b011 via mask_wr_en -> y=0 at state 4, y=1 at state 5, y=1 at state 2.
- en=1 with tbl_wr_en, tbl_wr_addr=state=3, tbl_wr_data=6 -> next state=4 (old entry); the next visit to state 3 goes to 6; cnt restarted.
- Reset asserted at state 5 with en=1 -> state=0, period_valid=0, cnt=0; the next full cycle reports period=8. With STATE_SEQ_GEN_PARITY_EN, a flipped parity bit on entry 0 -> parity_err=1 after the advance from 0.

Source files
------------

// File: rtl/state_seq_gen_pkg.sv
// Shared helpers for state_seq_gen: table depth, period width and the
// binary-counter table used as the reset image.
package state_seq_gen_pkg;

  function automatic int unsigned tbl_depth(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic int unsigned period_w(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned default_next(input int unsigned i, input int unsigned w);
    return (i + 1) % tbl_depth(w);
  endfunction

endpackage

// File: rtl/seq_period_mon.sv
// Period monitor: counts advances between visits to the reference state,
// reports the period, and flags sequences that never come back.
module seq_period_mon
  import state_seq_gen_pkg::*;
#(
  parameter int STATE_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         advance,
  input  logic                         next_is_ref,
  input  logic                         clear,
  output logic [period_w(STATE_W)-1:0] period,
  output logic                         period_valid,
  output logic                         no_return
);

  localparam int PW = period_w(STATE_W);
  localparam logic [PW-1:0] CNT_MAX = PW'(tbl_depth(STATE_W) - 1);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic          r_period_valid;
  logic          r_no_return;

  // NOTE: sequential state is only ever assigned with <=, so every read in
  // this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_no_return    <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (clear) begin
        r_cnt       <= '0;
        r_no_return <= 1'b0;
      end else if (advance) begin
        if (next_is_ref) begin
          r_period       <= r_cnt + 1'b1;
          r_period_valid <= 1'b1;
          r_cnt          <= '0;
        end else if (r_cnt == CNT_MAX) begin
          // Holding at depth-1 keeps a late return reporting the maximum period.
          r_no_return <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign no_return    = r_no_return;

endmodule

// File: rtl/state_seq_gen.sv
// Programmable state-sequence generator with period/lockup monitor.
// Optional table parity checking is enabled with `define STATE_SEQ_GEN_PARITY_EN.
module state_seq_gen
  import state_seq_gen_pkg::*;
#(
  parameter int                 STATE_W     = 3,
  parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         tbl_wr_en,
  input  logic [STATE_W-1:0]           tbl_wr_addr,
  input  logic [STATE_W-1:0]           tbl_wr_data,
`ifdef STATE_SEQ_GEN_PARITY_EN
  input  logic                         tbl_wr_par_inv,
`endif
  input  logic                         mask_wr_en,
  input  logic [STATE_W-1:0]           mask_in,
  output logic [STATE_W-1:0]           state,
  output logic                         y,
  output logic                         period_valid,
  output logic [period_w(STATE_W)-1:0] period,
  output logic                         stuck,
  output logic                         no_return,
  output logic                         parity_err
);

  localparam int DEPTH = tbl_depth(STATE_W);

  logic [STATE_W-1:0] r_tbl [DEPTH];
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_mask;
  logic               r_stuck;
  logic [STATE_W-1:0] w_next;

  assign w_next = r_tbl[r_state];

  // NOTE: the table is a small register file, not RAM, so it is reset to a
  // known counter image; the same-edge write cannot disturb the w_next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= STATE_W'(default_next(i, STATE_W));
      end
      r_state <= RESET_STATE;
      r_mask  <= '1;
      r_stuck <= 1'b0;
    end else begin
      if (tbl_wr_en) r_tbl[tbl_wr_addr] <= tbl_wr_data;
      if (en) r_state <= w_next;
      if (mask_wr_en) r_mask <= mask_in;
      if (tbl_wr_en) r_stuck <= 1'b0;
      else if (en && (w_next == r_state)) r_stuck <= 1'b1;
    end
  end

  seq_period_mon #(.STATE_W(STATE_W)) u_mon (
    .clk          (clk),
    .reset        (reset),
    .advance      (en),
    .next_is_ref  (w_next == RESET_STATE),
    .clear        (tbl_wr_en),
    .period       (period),
    .period_valid (period_valid),
    .no_return    (no_return)
  );

`ifdef STATE_SEQ_GEN_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_parity_err;

  // Even parity: the stored bit equals the XOR of the entry bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_par[i] <= ^(STATE_W'(default_next(i, STATE_W)));
      end
      r_parity_err <= 1'b0;
    end else begin
      if (tbl_wr_en) r_par[tbl_wr_addr] <= (^tbl_wr_data) ^ tbl_wr_par_inv;
      if (en && ((^w_next) != r_par[r_state])) r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign state = r_state;
  assign stuck = r_stuck;
  assign y     = |(r_state & r_mask);

endmodule

// File: tb/tb_state_seq_gen.sv
// Self-checking bench for state_seq_gen: directed sequences with direct
// checks plus a scoreboard for period reports.
module tb_state_seq_gen;

  localparam int STATE_W = 3;

  logic               clk;
  logic               reset;
  logic               en;
  logic               tbl_wr_en;
  logic [STATE_W-1:0] tbl_wr_addr;
  logic [STATE_W-1:0] tbl_wr_data;
`ifdef STATE_SEQ_GEN_PARITY_EN
  logic               tbl_wr_par_inv;
`endif
  logic               mask_wr_en;
  logic [STATE_W-1:0] mask_in;
  logic [STATE_W-1:0] state;
  logic               y;
  logic               period_valid;
  logic [STATE_W:0]   period;
  logic               stuck;
  logic               no_return;
  logic               parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  state_seq_gen #(.STATE_W(STATE_W), .RESET_STATE(3'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
`ifdef STATE_SEQ_GEN_PARITY_EN
    .tbl_wr_par_inv (tbl_wr_par_inv),
`endif
    .mask_wr_en   (mask_wr_en),
    .mask_in      (mask_in),
    .state        (state),
    .y            (y),
    .period_valid (period_valid),
    .period       (period),
    .stuck        (stuck),
    .no_return    (no_return),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every period_valid pulse must match a queued period.
  initial begin
    forever begin
      @(negedge clk);
      if (period_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_period: got %0d expected no pulse at %0t", period, $time);
        end else begin
          check("period", 32'(period), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [STATE_W-1:0] a, input logic [STATE_W-1:0] d);
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic adv(input logic [STATE_W-1:0] exp_state);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("state", 32'(state), 32'(exp_state));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    mask_wr_en = 1'b0; mask_in = '0;
`ifdef STATE_SEQ_GEN_PARITY_EN
    tbl_wr_par_inv = 1'b0;
`endif
    tick();
    do_reset();
    check("rst_state", 32'(state), 0);
    check("rst_period", 32'(period), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_no_return", 32'(no_return), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_y", 32'(y), 0);

    // Counter table: 1..7,0 with one period report of 8.
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(8);
      adv(3'(i % 8));
    end
    check("cnt_period", 32'(period), 8);
    check("cnt_stuck", 32'(stuck), 0);
    check("cnt_no_return", 32'(no_return), 0);
    tick();

    // Self-loop at 2 sets stuck; rewriting the entry clears it.
    do_reset();
    wr(3'd2, 3'd2);
    adv(3'd1);
    adv(3'd2);
    check("stuck_before", 32'(stuck), 0);
    adv(3'd2);
    check("stuck_set", 32'(stuck), 1);
    adv(3'd2);
    wr(3'd2, 3'd3);
    check("stuck_cleared", 32'(stuck), 0);

    // 2<->1 loop never returns to 0.
    do_reset();
    wr(3'd1, 3'd2);
    wr(3'd2, 3'd1);
    for (int i = 1; i <= 7; i++) adv((i % 2) ? 3'd1 : 3'd2);
    check("no_return_early", 32'(no_return), 0);
    adv(3'd2);
    check("no_return_set", 32'(no_return), 1);
    check("no_return_period", 32'(period), 0);

    // Output mask.
    do_reset();
    for (int i = 1; i <= 4; i++) adv(3'(i));
    check("y_full_mask_s4", 32'(y), 1);
    mask_wr_en = 1'b1; mask_in = 3'b011;
    tick();
    mask_wr_en = 1'b0;
    check("y_mask_s4", 32'(y), 0);
    adv(3'd5);
    check("y_mask_s5", 32'(y), 1);
    adv(3'd6);
    adv(3'd7);
    exp_q.push_back(8);
    adv(3'd0);
    adv(3'd1);
    adv(3'd2);
    check("y_mask_s2", 32'(y), 1);

    // Read-before-write on the current entry, cnt restart.
    do_reset();
    for (int i = 1; i <= 3; i++) adv(3'(i));
    en = 1'b1; tbl_wr_en = 1'b1; tbl_wr_addr = 3'd3; tbl_wr_data = 3'd6;
    tick();
    en = 1'b0; tbl_wr_en = 1'b0;
    check("rbw_state", 32'(state), 4);
    adv(3'd5);
    adv(3'd6);
    adv(3'd7);
    exp_q.push_back(4);
    adv(3'd0);
    adv(3'd1);
    adv(3'd2);
    adv(3'd3);
    adv(3'd6);
    adv(3'd7);
    exp_q.push_back(6);
    adv(3'd0);

    // Reset mid-sequence with en asserted discards the partial period.
    do_reset();
    for (int i = 1; i <= 5; i++) adv(3'(i));
    reset = 1'b1; en = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    check("midrst_state", 32'(state), 0);
    check("midrst_period", 32'(period), 0);
    check("midrst_valid", 32'(period_valid), 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(8);
      adv(3'(i % 8));
    end
    check("midrst_next_period", 32'(period), 8);

`ifdef STATE_SEQ_GEN_PARITY_EN
    // Corrupted parity on entry 0 is flagged on the advance from 0.
    do_reset();
    tbl_wr_par_inv = 1'b1;
    wr(3'd0, 3'd1);
    tbl_wr_par_inv = 1'b0;
    check("par_before", 32'(parity_err), 0);
    adv(3'd1);
    check("par_err", 32'(parity_err), 1);
`endif

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
